// File: rtl/offset_estimator_if.sv
// offset_estimator_if: control, sample stream and offset result bundle for offset_estimator
interface offset_estimator_if #(parameter int N = 384, parameter int W = 16);
    logic                start;
    logic                in_valid;
    logic signed [W-1:0] in_data;
    logic                in_ready;
    logic                busy;
    logic                done;
    logic [N-1:0]        out;
    modport master(output start, in_valid, in_data, input in_ready, busy, done, out);
    modport slave(input start, in_valid, in_data, output in_ready, busy, done, out);
endinterface

// File: rtl/offset_estimator.sv
// offset_estimator: averages 2^LOG2F interleaved frames of NCH signed channels into rounded per-channel offsets
module offset_estimator #(
    parameter int N     = 384,
    parameter int NCH   = 24,
    parameter int W     = 16,
    parameter int LOG2F = 4
) (
    input logic clk,
    input logic rst_n,
    offset_estimator_if.slave bus
);
    localparam int AW = W + LOG2F;
    localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
    localparam logic signed [AW-1:0] HALF = AW'(1 << (LOG2F - 1));
    typedef enum logic [1:0] {IDLE, ACCUM, UPDATE, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] ch;
    logic [LOG2F-1:0] fr;
    logic signed [AW-1:0] acc [NCH];
    logic [N-1:0] off;
    logic acc_en, wrap, last;
    assign acc_en = bus.in_valid && state == ACCUM;
    assign wrap = ch == CW'(NCH - 1);
    assign last = wrap && fr == {LOG2F{1'b1}};
    assign bus.in_ready = state == ACCUM;
    assign bus.busy = state != IDLE;
    assign bus.done = state == DONE;
    assign bus.out = off;
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE   ? (bus.start ? ACCUM : IDLE) :
                   state == ACCUM  ? (acc_en && last ? UPDATE : ACCUM) :
                   state == UPDATE ? DONE : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch <= '0;
            fr <= '0;
            for (int i = 0; i < NCH; i++) acc[i] <= '0;
        end else if (state == IDLE && bus.start) begin
            ch <= '0;
            fr <= '0;
            for (int i = 0; i < NCH; i++) acc[i] <= '0;
        end else if (acc_en) begin
            acc[ch] <= acc[ch] + {{LOG2F{bus.in_data[W-1]}}, bus.in_data};
            ch <= wrap ? '0 : ch + CW'(1);
            fr <= fr + LOG2F'(wrap);
        end
    end
    // Accumulator width leaves headroom for the rounding bias, so no saturation is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            off <= '0;
        else if (state == UPDATE)
            for (int i = 0; i < NCH; i++) off[i*W +: W] <= W'((acc[i] + HALF) >>> LOG2F);
    end
endmodule

// File: tb/tb_offset_estimator.sv
// tb_offset_estimator: randomized scoreboard bench for offset_estimator against a per-channel averaging model
module tb_offset_estimator;
    localparam int NCH = 24, W = 16, LOG2F = 4, N = NCH * W, F = 1 << LOG2F, S = NCH * F;
    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;
    offset_estimator_if #(.N(N), .W(W)) bus();
    offset_estimator #(.N(N), .NCH(NCH), .W(W), .LOG2F(LOG2F)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int total = 0, bad = 0, dones = 0, runs = 0;
    logic [N-1:0] expq [$];
    logic [N-1:0] cur_exp = '0;
    logic [N-1:0] gapfree;
    logic signed [W-1:0] smp [S];

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, want);
        end
    endtask

    task automatic fill(input int mode);
        for (int f = 0; f < F; f++)
            for (int k = 0; k < NCH; k++)
                case (mode)
                    0: smp[f*NCH+k] = W'(k - 12);
                    1: smp[f*NCH+k] = k == 0 ? W'(f % 2 + 1) : '0;
                    2: smp[f*NCH+k] = k == 0 ? -16'sd1 : '0;
                    3: smp[f*NCH+k] = 16'sh8000;
                    4: smp[f*NCH+k] = 16'sh7fff;
                    default: smp[f*NCH+k] = W'($urandom);
                endcase
    endtask

    function automatic logic [N-1:0] predict();
        logic [N-1:0] v;
        v = '0;
        for (int k = 0; k < NCH; k++) begin
            int s, t, q;
            s = 0;
            for (int f = 0; f < F; f++) s += int'(smp[f*NCH+k]);
            t = s + F / 2;
            q = t >= 0 ? t / F : -((-t + F - 1) / F);
            v[k*W +: W] = q[W-1:0];
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            dones++;
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 want no pending result");
            end else begin
                chk("scoreboard_out", bus.out, expq.pop_front());
            end
        end
    end

    task automatic run(input int gap, input bit stpulse, input int abort_at);
        int idx, cyc;
        logic [N-1:0] pred;
        pred = predict();
        if (abort_at == 0) expq.push_back(pred);
        @(posedge clk); #1;
        bus.start = 1;
        bus.in_valid = 1;
        bus.in_data = 16'sh7abc;
        @(posedge clk); #1;
        bus.start = 0;
        idx = 0;
        cyc = 0;
        while (idx < S && cyc < 20000 && !(abort_at > 0 && idx >= abort_at)) begin
            bus.in_valid = $urandom_range(99) >= gap;
            bus.in_data = smp[idx];
            if (stpulse) bus.start = $urandom_range(3) == 0;
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                if (idx % NCH == 0) chk("hold_out", bus.out, cur_exp);
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid = 0;
        if (cyc >= 20000) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d accepts want %0d", idx, S);
        end
        if (abort_at > 0) begin
            bus.start = 0;
            #2 rst_n = 0;
            #1;
            chk("abort_out", bus.out, '0);
            chk1("abort_busy", bus.busy, 1'b0);
            chk1("abort_ready", bus.in_ready, 1'b0);
            chk1("abort_done", bus.done, 1'b0);
            @(posedge clk); @(posedge clk); #1;
            rst_n = 1;
            repeat (3) @(negedge clk);
            chk1("post_reset_idle", bus.busy, 1'b0);
            cur_exp = '0;
            return;
        end
        if (stpulse) bus.start = 1;
        @(negedge clk);
        chk1("update_ready", bus.in_ready, 1'b0);
        chk1("update_done", bus.done, 1'b0);
        chk1("update_busy", bus.busy, 1'b1);
        @(posedge clk); #1;
        bus.start = 0;
        @(negedge clk);
        chk1("done_pulse", bus.done, 1'b1);
        @(negedge clk);
        chk1("done_end", bus.done, 1'b0);
        chk1("idle_busy", bus.busy, 1'b0);
        cur_exp = pred;
        runs++;
    endtask

    initial begin
        bus.start = 0;
        bus.in_valid = 0;
        bus.in_data = '0;
        #12;
        chk("reset_out", bus.out, '0);
        chk1("reset_ready", bus.in_ready, 1'b0);
        chk1("reset_busy", bus.busy, 1'b0);
        chk1("reset_done", bus.done, 1'b0);
        @(negedge clk);
        rst_n = 1;
        bus.in_valid = 1;
        repeat (3) @(negedge clk);
        chk1("idle_wait", bus.busy, 1'b0);
        bus.in_valid = 0;
        fill(0); run(0, 0, 0);
        chk("ramp_ch0", bus.out[15:0], 16'hfff4);
        chk("ramp_ch23", bus.out[383:368], 16'h000b);
        gapfree = bus.out;
        fill(1); run(0, 0, 0);
        chk("alt_ch0", bus.out[15:0], 16'h0002);
        fill(2); run(10, 0, 0);
        chk("neg1_ch0", bus.out[15:0], 16'hffff);
        fill(3); run(0, 0, 0);
        chk("min_ch5", bus.out[95:80], 16'h8000);
        fill(4); run(0, 0, 0);
        chk("max_ch9", bus.out[159:144], 16'h7fff);
        fill(0); run(30, 0, 0);
        chk("gap_same", bus.out, gapfree);
        fill(5); run(25, 1, 0);
        fill(5); run(20, 0, 100);
        fill(5); run(15, 1, 0);
        fill(5); run(0, 0, 0);
        fill(5); run(40, 0, 0);
        repeat (4) @(negedge clk);
        total++;
        if (dones != runs || expq.size() != 0) begin
            bad++;
            $display("FAIL done_count: got %0d pulses want %0d (pending %0d)", dones, runs, expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/offset_estimator.md
OFFSET_ESTIMATOR -- requirements
Module: offset_estimator

Interface
REQ-001 SHALL have parameter N, default 384: packed offset vector width; N = NCH*W.
REQ-002 SHALL have parameter NCH, default 24: number of channels.
REQ-003 SHALL have parameter W, default 16: sample and offset width, two's complement.
REQ-004 SHALL have parameter LOG2F, default 4: averaging depth is 2^LOG2F frames; legal range 1..8.
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1: begin a new estimation; sampled in IDLE only.
REQ-008 SHALL have port in_valid, input, 1: in_data carries a sample.
REQ-009 SHALL have port in_data, input, W: signed sample for the current channel.
REQ-010 SHALL have port in_ready, output, 1: block accepts a sample this cycle.
REQ-011 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1: one-cycle pulse when offset_out is updated.
REQ-013 SHALL have port out, output, N: packed offsets; channel k at bits [16k+15:16k], channel 0 at [15:0], channel 23 at [383:368].

Function
REQ-014 SHALL implement the FSM IDLE -> ACCUM -> UPDATE -> DONE -> IDLE.
REQ-015 IDLE with start=1 SHALL, on that edge, clear all NCH accumulators, set channel counter to 0, set frame counter to 0, and enter ACCUM.
REQ-016 start SHALL be ignored outside IDLE.
REQ-017 in_ready SHALL be 1 in ACCUM only; a sample is accepted on a cycle where in_valid and in_ready are both 1.
REQ-018 Each accepted sample SHALL be sign-extended and added to acc[channel]; each accumulator is W+LOG2F bits wide and cannot overflow.
REQ-019 Channel counter SHALL increment on each accepted sample.
REQ-020 Channel counter SHALL wrap from NCH-1 to 0, and the frame counter SHALL increment on that wrap.
REQ-021 Cycles with in_valid=0 SHALL hold all counters and accumulators (bubbles allowed).
REQ-022 Acceptance of the sample with channel=NCH-1 and frame=2^LOG2F-1 SHALL move the FSM to UPDATE, with in_ready dropping the next cycle.
REQ-023 UPDATE SHALL last one cycle.
REQ-024 In UPDATE, every channel offset SHALL be latched as (acc[k] + 2^(LOG2F-1)) arithmetically shifted right by LOG2F, keeping the low W bits.
REQ-025 The UPDATE result SHALL be round-half-up and SHALL need no saturation.
REQ-026 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-027 out SHALL change only in UPDATE and SHALL hold its value through IDLE and any following estimation until the next UPDATE.
REQ-028 start and in_valid arriving in the same cycle in IDLE SHALL NOT accept the sample; the first sample can be accepted in the first ACCUM cycle.
REQ-029 A partial estimation SHALL have no abort except reset; accumulators are not visible on outputs.

Reset
REQ-030 rst_n=0 SHALL immediately, without waiting for clk, force state IDLE and clear both counters and all accumulators.
REQ-031 rst_n=0 SHALL force out=0, in_ready=0, busy=0, done=0.
REQ-032 Reset asserted mid-ACCUM or in UPDATE SHALL discard the estimation, and out SHALL read 0 after reset.
REQ-033 After rst_n rises, the block SHALL stay in IDLE until start.

Verification
REQ-034 Default parameters, all 16 frames with channel k = k-12 every sample -> done after the 384th accept; out[15:0]=16'hfff4, out[383:368]=16'h000b.
REQ-035 Channel 0 alternating 1,2 per frame (sum 24, +8, >>4 = 2), others 0 -> out[15:0]=16'h0002; channel 0 all -1 -> 16'hffff; all 16'h8000 -> 16'h8000; all 16'h7fff -> 16'h7fff.
REQ-036 Random in_valid gaps over a full run -> same out as the gap-free run; exactly one done pulse, two cycles after the final accept.
REQ-037 start pulses during ACCUM and UPDATE -> ignored, counts unaffected; start in IDLE with in_valid=1 -> that sample not accepted.
REQ-038 rst_n low after 100 accepts, then a fresh full run -> out is 0 right after reset and the final out uses only the fresh samples.
REQ-039 Two back-to-back runs -> out holds the first result through the entire second ACCUM and changes only at the second UPDATE.
